debug_ram_arbiter: RTL and testbench
====================================

# debug_ram_arbiter

Single-port access arbiter for the 1024x8 debug RAM behind the binary display. It shares the RAM's one address/data port between the display read path (absolute priority) and two write requesters, A (cellular-automaton engine) and B (host/debug loader), using round-robin between writers. Every RAM control output is registered, and display read data is returned with a fixed latency so the pixel pipeline can rely on deterministic timing.

## Interface
- AW, 10, RAM address width
- DW, 8, RAM data width
- STARVE_LIMIT, 1023, wait-cycle threshold for the starvation flag (only with ARB_STARVE_EN)

- clk  in  1  pixel clock, single clock domain
- rst_n  in  1  asynchronous active-low reset
- disp_req  in  1  display read request, sampled every cycle
- disp_addr  in  AW  display read address
- disp_data  out  DW  registered read data
- disp_valid  out  1  disp_data valid this cycle
- wa_req / wb_req  in  1  write request, held until granted
- wa_addr / wb_addr  in  AW  write address, stable while req high
- wa_data / wb_data  in  DW  write data, stable while req high
- wa_gnt / wb_gnt  out  1  one-cycle grant pulse
- ram_addr  out  AW  RAM address
- ram_wdata  out  DW  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  DW  RAM read data, synchronous, valid one cycle after address
- starve  out  1  sticky starvation flag

## Operation
- Owner register (state): IDLE, RD, WA, WB; chosen each cycle N from inputs, registered at the end of N, drives the RAM during N+1.
- Priority in cycle N: disp_req -> RD; else eligible writer(s) -> WA/WB; else IDLE.
- A writer is eligible when its req is high and its gnt is low in cycle N. This masks the requester already being serviced.
- Round-robin: rr pointer (reset = A). With both writers eligible, the pointer's writer wins. The pointer flips to the other writer after each write grant. A lone eligible writer wins regardless of the pointer. RD does not move the pointer.
- RD: ram_addr=disp_addr, ram_we=0. WA/WB: ram_addr/ram_wdata from that writer, ram_we=1, matching gnt=1. IDLE: ram_we=0, and ram_addr/ram_wdata hold their last values.
- The writer drops req, or presents its next transaction, on the cycle after gnt.
- Display never stalls. Writers wait indefinitely while disp_req stays high.
- Widths are exact AW/DW; there is no address translation and no wrap logic. Out-of-range addresses cannot occur.

## Timing
- Reset values: owner=IDLE, rr=A, ram_we=0, ram_addr=0, ram_wdata=0, wa_gnt=wb_gnt=0, disp_valid=0, disp_data=0, starve=0.
- Read latency: disp_req in cycle N -> ram_addr in N+1 -> ram_rdata in N+2 -> disp_data/disp_valid registered in N+3. The latency is always 3 cycles.
- Write: req in N with no disp_req -> ram_we and gnt in N+1. The RAM captures the write at the end of N+1.
- Throughput: one access per cycle overall. A single writer gets at most one write per 2 cycles. A and B alternating reach one write per cycle.
- Back-to-back disp_req: one read per cycle, with disp_valid continuous 3 cycles later.
- Reset mid-operation: the in-flight grant and read are discarded. A writer still holding req is re-granted after reset.
- A read and a write in consecutive cycles to the same address: the read returns whatever the RAM gives, and no forwarding is performed.

## Configuration
- ARB_STARVE_EN defined:
  - Each writer has a wait counter. It increments every cycle the writer's req is high without a grant, and clears on grant.
  - Counter width is clog2(STARVE_LIMIT+1), saturating.
  - starve sets when either counter reaches STARVE_LIMIT and stays set until rst_n.
- ARB_STARVE_EN undefined: no counters are built, and starve is tied to 0.

## Test plan
- Read only: disp_req for cycles 5..9 with addr 0x010..0x014, RAM preloaded with value=addr[7:0] -> disp_valid cycles 8..12, disp_data 0x10..0x14, ram_we=0 throughout.
- Single writer: wa_req with addr 0x3FF, data 0xA5, no display -> wa_gnt and ram_we one cycle later, ram_addr=0x3FF, ram_wdata=0xA5. A subsequent read returns 0xA5.
- Contention: wa_req and wb_req both held for 4 transactions each -> grants alternate A,B,A,B… starting with A after reset, one ram_we per cycle.
- Display priority: disp_req held 20 cycles while wa_req high -> no wa_gnt during the window. The first wa_gnt arrives one cycle after disp_req falls.
- Reset mid-write: assert rst_n=0 in the same cycle as wb_gnt -> all outputs are at reset values immediately. After release, wb_gnt repeats for the held request.
- ARB_STARVE_EN with STARVE_LIMIT=8: disp_req held 12 cycles with wa_req high -> starve rises after 8 wait cycles and stays 1 after the grant. Without the macro, starve=0.

Source files
------------

// File: rtl/debug_ram_arbiter.sv
// debug_ram_arbiter: shares the single port of the 1024x8 debug RAM between the
// display read path (absolute priority) and two round-robin write requesters.
// All RAM controls and grants are registered. Display data returns exactly 3
// cycles after disp_req.
// Optional feature macro: ARB_STARVE_EN adds per-writer wait counters and a
// sticky starvation flag. When the macro is undefined, o_starve is tied to 0.
module debug_ram_arbiter #(
  parameter int unsigned AW           = 10,
  parameter int unsigned DW           = 8,
  parameter int unsigned STARVE_LIMIT = 1023
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_disp_req,
  input  logic [AW-1:0] i_disp_addr,
  output logic [DW-1:0] o_disp_data,
  output logic          o_disp_valid,
  input  logic          i_wa_req,
  input  logic [AW-1:0] i_wa_addr,
  input  logic [DW-1:0] i_wa_data,
  output logic          o_wa_gnt,
  input  logic          i_wb_req,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_wb_gnt,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  output logic          o_ram_we,
  input  logic [DW-1:0] i_ram_rdata,
  output logic          o_starve
);

  typedef enum logic [1:0] {
    OWN_IDLE = 2'd0,
    OWN_RD   = 2'd1,
    OWN_WA   = 2'd2,
    OWN_WB   = 2'd3
  } owner_t;

  owner_t        r_owner;
  logic          r_rr_b;        // 0: A wins a tie, 1: B wins a tie
  logic          r_wa_gnt;
  logic          r_wb_gnt;
  logic          r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_wdata;
  logic          r_rd_d1;       // RAM read data arrives in this cycle
  logic          r_disp_valid;
  logic [DW-1:0] r_disp_data;

  logic          w_wa_elig;
  logic          w_wb_elig;
  owner_t        w_next_owner;

  // A writer being granted this cycle is masked so it is not granted twice
  assign w_wa_elig = i_wa_req & ~r_wa_gnt;
  assign w_wb_elig = i_wb_req & ~r_wb_gnt;

  // Next owner: display first, then round-robin between eligible writers
  always_comb begin
    w_next_owner = OWN_IDLE;
    if (i_disp_req) begin
      w_next_owner = OWN_RD;
    end else if (w_wa_elig && w_wb_elig) begin
      w_next_owner = r_rr_b ? OWN_WB : OWN_WA;
    end else if (w_wa_elig) begin
      w_next_owner = OWN_WA;
    end else if (w_wb_elig) begin
      w_next_owner = OWN_WB;
    end
  end

  // Owner register, RAM port drive, grants and round-robin pointer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_IDLE;
      r_rr_b      <= 1'b0;
      r_wa_gnt    <= 1'b0;
      r_wb_gnt    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_owner  <= w_next_owner;
      r_wa_gnt <= 1'b0;
      r_wb_gnt <= 1'b0;
      r_ram_we <= 1'b0;
      case (w_next_owner)
        OWN_RD: begin
          r_ram_addr <= i_disp_addr;
        end
        OWN_WA: begin
          r_ram_addr  <= i_wa_addr;
          r_ram_wdata <= i_wa_data;
          r_ram_we    <= 1'b1;
          r_wa_gnt    <= 1'b1;
          r_rr_b      <= 1'b1;
        end
        OWN_WB: begin
          r_ram_addr  <= i_wb_addr;
          r_ram_wdata <= i_wb_data;
          r_ram_we    <= 1'b1;
          r_wb_gnt    <= 1'b1;
          r_rr_b      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Fixed-latency read return: track the read through the RAM and register its data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_d1      <= 1'b0;
      r_disp_valid <= 1'b0;
      r_disp_data  <= '0;
    end else begin
      r_rd_d1      <= (r_owner == OWN_RD);
      r_disp_valid <= r_rd_d1;
      if (r_rd_d1) begin
        r_disp_data <= i_ram_rdata;
      end
    end
  end

`ifdef ARB_STARVE_EN
  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  logic [WAIT_W-1:0] r_wa_wait;
  logic [WAIT_W-1:0] r_wb_wait;
  logic              r_starve;

  // Saturating wait counters per writer and a sticky starvation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wa_wait <= '0;
      r_wb_wait <= '0;
      r_starve  <= 1'b0;
    end else begin
      if (r_wa_gnt) begin
        r_wa_wait <= '0;
      end else if (i_wa_req && (r_wa_wait != WAIT_MAX)) begin
        r_wa_wait <= r_wa_wait + WAIT_W'(1);
      end
      if (r_wb_gnt) begin
        r_wb_wait <= '0;
      end else if (i_wb_req && (r_wb_wait != WAIT_MAX)) begin
        r_wb_wait <= r_wb_wait + WAIT_W'(1);
      end
      if ((r_wa_wait == WAIT_MAX) || (r_wb_wait == WAIT_MAX)) begin
        r_starve <= 1'b1;
      end
    end
  end

  assign o_starve = r_starve;
`else
  assign o_starve = 1'b0;
`endif

  assign o_wa_gnt     = r_wa_gnt;
  assign o_wb_gnt     = r_wb_gnt;
  assign o_ram_we     = r_ram_we;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_wdata  = r_ram_wdata;
  assign o_disp_valid = r_disp_valid;
  assign o_disp_data  = r_disp_data;

endmodule

// File: tb/tb_debug_ram_arbiter.sv
// Directed bench for debug_ram_arbiter with a behavioural 1024x8 synchronous RAM.
// Honours ARB_STARVE_EN (starvation limit set to 8 for the bench).
module tb_debug_ram_arbiter;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;
`ifdef ARB_STARVE_EN
  localparam logic STARVE_ON = 1'b1;
`else
  localparam logic STARVE_ON = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          wa_req;
  logic [AW-1:0] wa_addr;
  logic [DW-1:0] wa_data;
  logic          wa_gnt;
  logic          wb_req;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_gnt;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic          starve;

  logic [DW-1:0] mem [0:1023];

  int n_checks;
  int n_errors;

  debug_ram_arbiter #(
    .AW(AW), .DW(DW), .STARVE_LIMIT(8)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_disp_req   (disp_req),
    .i_disp_addr  (disp_addr),
    .o_disp_data  (disp_data),
    .o_disp_valid (disp_valid),
    .i_wa_req     (wa_req),
    .i_wa_addr    (wa_addr),
    .i_wa_data    (wa_data),
    .o_wa_gnt     (wa_gnt),
    .i_wb_req     (wb_req),
    .i_wb_addr    (wb_addr),
    .i_wb_data    (wb_data),
    .o_wb_gnt     (wb_gnt),
    .o_ram_addr   (ram_addr),
    .o_ram_wdata  (ram_wdata),
    .o_ram_we     (ram_we),
    .i_ram_rdata  (ram_rdata),
    .o_starve     (starve)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read-before-write, data valid one cycle after address
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] <= ram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},     32'(ram_we), 32'd0);
    chk({tag, "_addr"},   32'(ram_addr), 32'd0);
    chk({tag, "_wdata"},  32'(ram_wdata), 32'd0);
    chk({tag, "_wagnt"},  32'(wa_gnt), 32'd0);
    chk({tag, "_wbgnt"},  32'(wb_gnt), 32'd0);
    chk({tag, "_dvalid"}, 32'(disp_valid), 32'd0);
    chk({tag, "_ddata"},  32'(disp_data), 32'd0);
    chk({tag, "_starve"}, 32'(starve), 32'd0);
  endtask

  initial begin
    int ia, ib, ngnt, nvalid;
    logic pa, pb;
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    disp_req  = 1'b0; disp_addr = '0;
    wa_req    = 1'b0; wa_addr = '0; wa_data = '0;
    wb_req    = 1'b0; wb_addr = '0; wb_data = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);

    // Reset values while held in reset
    #3;
    chk_reset_vals("rst");
    tick();
    rst_n = 1'b1;

    // Read only: five back-to-back reads of 0x010..0x014
    for (int c = 0; c < 10; c++) begin
      disp_req  = (c < 5);
      disp_addr = 10'(16 + c);
      chk("rd_we", 32'(ram_we), 32'd0);
      if (c >= 1 && c <= 5) chk("rd_addr", 32'(ram_addr), 32'(16 + c - 1));
      chk("rd_valid", 32'(disp_valid), 32'((c >= 3 && c <= 7) ? 1 : 0));
      if (c >= 3 && c <= 7) chk("rd_data", 32'(disp_data), 32'(16 + c - 3));
      tick();
    end

    // Single writer A: 0x3FF <= 0xA5
    wa_req = 1'b1; wa_addr = 10'h3FF; wa_data = 8'hA5;
    tick();
    chk("wa_gnt", 32'(wa_gnt), 32'd1);
    chk("wa_we", 32'(ram_we), 32'd1);
    chk("wa_addr", 32'(ram_addr), 32'h3FF);
    chk("wa_wdata", 32'(ram_wdata), 32'hA5);
    tick();
    wa_req = 1'b0;
    chk("wa_masked_gnt", 32'(wa_gnt), 32'd0);
    chk("wa_masked_we", 32'(ram_we), 32'd0);
    disp_req = 1'b1; disp_addr = 10'h3FF;
    tick();
    disp_req = 1'b0;
    tick();
    tick();
    chk("rbw_valid", 32'(disp_valid), 32'd1);
    chk("rbw_data", 32'(disp_data), 32'hA5);

    // Contention: A and B each present 4 writes, grants alternate from A
    do_reset();
    ia = 0; ib = 0; pa = 1'b0; pb = 1'b0;
    wa_req = 1'b1; wa_addr = 10'h100; wa_data = 8'hA0;
    wb_req = 1'b1; wb_addr = 10'h200; wb_data = 8'hB0;
    for (int c = 0; c < 10; c++) begin
      if (pa) begin
        ia++;
        if (ia == 4) wa_req = 1'b0;
        else begin wa_addr = 10'(256 + ia); wa_data = 8'(160 + ia); end
      end
      if (pb) begin
        ib++;
        if (ib == 4) wb_req = 1'b0;
        else begin wb_addr = 10'(512 + ib); wb_data = 8'(176 + ib); end
      end
      if (c >= 1 && c <= 8) begin
        chk("rr_agnt", 32'(wa_gnt), 32'(c % 2));
        chk("rr_bgnt", 32'(wb_gnt), 32'(1 - (c % 2)));
        chk("rr_we", 32'(ram_we), 32'd1);
        if (c % 2 == 1) begin
          chk("rr_addr", 32'(ram_addr), 32'(256 + (c - 1) / 2));
          chk("rr_wdata", 32'(ram_wdata), 32'(160 + (c - 1) / 2));
        end else begin
          chk("rr_addr", 32'(ram_addr), 32'(512 + c / 2 - 1));
          chk("rr_wdata", 32'(ram_wdata), 32'(176 + c / 2 - 1));
        end
      end
      if (c == 9) chk("rr_done_we", 32'(ram_we), 32'd0);
      pa = wa_gnt;
      pb = wb_gnt;
      tick();
    end

    // Display priority over a waiting writer for 20 cycles (also starvation)
    do_reset();
    wa_req = 1'b1; wa_addr = 10'h2AA; wa_data = 8'h5A;
    ngnt = 0; nvalid = 0;
    for (int c = 0; c < 23; c++) begin
      disp_req  = (c < 20);
      disp_addr = 10'(c);
      if (c <= 20 && wa_gnt) ngnt++;
      if (c >= 3 && disp_valid) nvalid++;
      if (c == 5)  chk("starve_early", 32'(starve), 32'd0);
      if (c == 19) chk("starve_set", 32'(starve), 32'(STARVE_ON));
      if (c == 21) begin
        chk("pri_gnt", 32'(wa_gnt), 32'd1);
        chk("pri_we", 32'(ram_we), 32'd1);
        chk("pri_addr", 32'(ram_addr), 32'h2AA);
        chk("pri_wdata", 32'(ram_wdata), 32'h5A);
      end
      if (c == 22) begin
        wa_req = 1'b0;
        chk("pri_last_data", 32'(disp_data), 32'd19);
      end
      tick();
    end
    chk("pri_no_gnt", 32'(ngnt), 32'd0);
    chk("pri_valid_run", 32'(nvalid), 32'd20);
    chk("starve_sticky", 32'(starve), 32'(STARVE_ON));

    // Reset asserted in the cycle of wb_gnt; held request is re-granted
    wb_req = 1'b1; wb_addr = 10'h055; wb_data = 8'h3C;
    tick();
    chk("mid_wbgnt", 32'(wb_gnt), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("mid");
    tick();
    rst_n = 1'b1;
    tick();
    chk("re_wbgnt", 32'(wb_gnt), 32'd1);
    chk("re_we", 32'(ram_we), 32'd1);
    chk("re_addr", 32'(ram_addr), 32'h055);
    chk("re_wdata", 32'(ram_wdata), 32'h3C);
    tick();
    wb_req = 1'b0;
    chk("re_masked", 32'(wb_gnt), 32'd0);
    tick();
    chk("re_idle_we", 32'(ram_we), 32'd0);
    chk("re_hold_addr", 32'(ram_addr), 32'h055);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
